// File: rtl/rdl_subreg_pkg.sv
// Shared types for RDL sub-register logic: write/read side-effect selectors
// and the read-responder state encoding.
package rdl_subreg_pkg;

  typedef enum logic [1:0] {
    OnWriteNone,
    OnWriteW1c,
    OnWriteW1s,
    OnWriteW0c
  } on_write_e;

  typedef enum logic [1:0] {
    OnReadNone,
    OnReadRclr,
    OnReadRset
  } on_read_e;

  typedef enum logic {
    RdIdle,
    RdResp
  } rd_state_e;

endpackage

// File: rtl/rdl_subreg_rd.sv
// CPU read responder for one RDL sub-register: 1-entry response hold, on-read
// side effects merged with the write arbiter. Optional swacc: RDL_SUBREG_RD_SWACC_EN.
module rdl_subreg_rd
  import rdl_subreg_pkg::*;
#(
  parameter int       DW     = 32,
  parameter on_read_e OnRead = OnReadNone
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  output logic          re_ready,
  input  logic [DW-1:0] q,
  input  logic          de,
  input  logic [DW-1:0] d,
  input  logic          arb_wr_en,
  input  logic [DW-1:0] arb_wr_data,
  output logic          wr_en,
  output logic [DW-1:0] wr_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data
`ifdef RDL_SUBREG_RD_SWACC_EN
  ,
  output logic          swacc
`endif
);

  if (OnRead != OnReadNone && OnRead != OnReadRclr && OnRead != OnReadRset) begin : g_bad_on_read
    $error("rdl_subreg_rd: unsupported OnRead value");
  end

  rd_state_e     r_state;
  rd_state_e     w_state_next;
  logic          w_acc;
  logic          w_sfx;
  logic [DW-1:0] w_sfx_data;
  logic [DW-1:0] r_rsp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RdIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    re_ready     = 1'b0;
    case (r_state)
      RdIdle:  re_ready = !rst;
      RdResp:  re_ready = !rst && rsp_ready;
      default: re_ready = 1'b0;
    endcase
    w_acc = re && re_ready;
    case (r_state)
      RdIdle:  if (w_acc) w_state_next = RdResp;
      RdResp:  if (rsp_ready && !w_acc) w_state_next = RdIdle;
      default: w_state_next = RdIdle;
    endcase
  end

  // Rclr keeps a same-cycle HW update instead of clearing over it.
  always_comb begin
    w_sfx      = 1'b0;
    w_sfx_data = '0;
    case (OnRead)
      OnReadRclr: begin
        w_sfx      = w_acc;
        w_sfx_data = de ? d : '0;
      end
      OnReadRset: begin
        w_sfx      = w_acc;
        w_sfx_data = '1;
      end
      default: begin
        w_sfx      = 1'b0;
        w_sfx_data = '0;
      end
    endcase
  end

  // Arbiter write outranks the read side effect; the read still returns old q.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (!rst) begin
      if (arb_wr_en) begin
        wr_en   = 1'b1;
        wr_data = arb_wr_data;
      end else if (w_sfx) begin
        wr_en   = 1'b1;
        wr_data = w_sfx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= '0;
    end else if (w_acc) begin
      r_rsp_data <= q;
    end
  end

  assign rsp_valid = (r_state == RdResp);
  assign rsp_data  = r_rsp_data;

`ifdef RDL_SUBREG_RD_SWACC_EN
  logic r_swacc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_swacc <= 1'b0;
    end else begin
      r_swacc <= w_acc;
    end
  end

  assign swacc = r_swacc;
`endif

endmodule

// File: tb/tb_rdl_subreg_rd.sv
// Bench for rdl_subreg_rd: three instances (None/Rclr/Rset) on shared inputs,
// directed scenarios plus a randomized run against a queue-based response model.
module tb_rdl_subreg_rd;
  import rdl_subreg_pkg::*;

  logic        clk = 1'b0;
  logic        rst, re, de, arb_wr_en, rsp_ready;
  logic [31:0] q, d, arb_wr_data;

  logic        n_re_ready, c_re_ready, s_re_ready;
  logic        n_wr_en, c_wr_en, s_wr_en;
  logic [31:0] n_wr_data, c_wr_data, s_wr_data;
  logic        n_rsp_valid, c_rsp_valid, s_rsp_valid;
  logic [31:0] n_rsp_data, c_rsp_data, s_rsp_data;
`ifdef RDL_SUBREG_RD_SWACC_EN
  logic        n_swacc, c_swacc, s_swacc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rdl_subreg_rd #(.DW(32), .OnRead(OnReadNone)) dut_none (
    .clk(clk), .rst(rst), .re(re), .re_ready(n_re_ready), .q(q), .de(de), .d(d),
    .arb_wr_en(arb_wr_en), .arb_wr_data(arb_wr_data), .wr_en(n_wr_en), .wr_data(n_wr_data),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(n_rsp_data)
`ifdef RDL_SUBREG_RD_SWACC_EN
    , .swacc(n_swacc)
`endif
  );

  rdl_subreg_rd #(.DW(32), .OnRead(OnReadRclr)) dut_rclr (
    .clk(clk), .rst(rst), .re(re), .re_ready(c_re_ready), .q(q), .de(de), .d(d),
    .arb_wr_en(arb_wr_en), .arb_wr_data(arb_wr_data), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(c_rsp_data)
`ifdef RDL_SUBREG_RD_SWACC_EN
    , .swacc(c_swacc)
`endif
  );

  rdl_subreg_rd #(.DW(32), .OnRead(OnReadRset)) dut_rset (
    .clk(clk), .rst(rst), .re(re), .re_ready(s_re_ready), .q(q), .de(de), .d(d),
    .arb_wr_en(arb_wr_en), .arb_wr_data(arb_wr_data), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data)
`ifdef RDL_SUBREG_RD_SWACC_EN
    , .swacc(s_swacc)
`endif
  );

  // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    re = 1'b0; de = 1'b0; d = '0; arb_wr_en = 1'b0; arb_wr_data = '0; q = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); re = 1'b1; arb_wr_en = 1'b1; arb_wr_data = 32'h1234;
    step(); step();
    #1;
    checks++; if (n_re_ready !== 1'b0) begin errors++; $display("FAIL reset_re_ready got=%b exp=0", n_re_ready); end
    checks++; if (n_wr_en !== 1'b0 || c_wr_en !== 1'b0 || s_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en got=%b%b%b exp=000", n_wr_en, c_wr_en, s_wr_en); end
    checks++; if (n_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", n_rsp_valid); end
    checks++; if (n_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", n_rsp_data); end
`ifdef RDL_SUBREG_RD_SWACC_EN
    checks++; if (n_swacc !== 1'b0) begin errors++; $display("FAIL reset_swacc got=%b exp=0", n_swacc); end
`endif
    rst = 1'b0; idle_inputs();
    step();
    $display("test_reset done");
  endtask

  task automatic test_read_none();
    q = 32'hA5A5_0001; re = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++; if (n_re_ready !== 1'b1) begin errors++; $display("FAIL none_re_ready got=%b exp=1", n_re_ready); end
    checks++; if (n_wr_en !== 1'b0) begin errors++; $display("FAIL none_wr_en_acc got=%b exp=0", n_wr_en); end
    step();
    re = 1'b0; q = 32'h0;
    #1;
    checks++; if (n_rsp_valid !== 1'b1) begin errors++; $display("FAIL none_rsp_valid got=%b exp=1", n_rsp_valid); end
    checks++; if (n_rsp_data !== 32'hA5A5_0001) begin errors++; $display("FAIL none_rsp_data got=%h exp=a5a50001", n_rsp_data); end
    checks++; if (n_wr_en !== 1'b0) begin errors++; $display("FAIL none_wr_en_rsp got=%b exp=0", n_wr_en); end
    step();
    checks++; if (n_rsp_valid !== 1'b0) begin errors++; $display("FAIL none_rsp_drain got=%b exp=0", n_rsp_valid); end
    $display("test_read_none done");
  endtask

  task automatic test_rclr();
    q = 32'h0000_00F0; re = 1'b1; de = 1'b0;
    #1;
    checks++; if (c_wr_en !== 1'b1 || c_wr_data !== 32'h0) begin
      errors++; $display("FAIL rclr_clear got=%b/%h exp=1/0", c_wr_en, c_wr_data); end
    checks++; if (s_wr_en !== 1'b1 || s_wr_data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rset_set got=%b/%h exp=1/ffffffff", s_wr_en, s_wr_data); end
    step();
    re = 1'b1; de = 1'b1; d = 32'h1; q = 32'h0000_0055;
    #1;
    checks++; if (c_rsp_data !== 32'h0000_00F0) begin errors++; $display("FAIL rclr_rsp_data got=%h exp=000000f0", c_rsp_data); end
    checks++; if (c_wr_en !== 1'b1 || c_wr_data !== 32'h1) begin
      errors++; $display("FAIL rclr_hw_wins got=%b/%h exp=1/1", c_wr_en, c_wr_data); end
    step();
    idle_inputs();
    #1;
    checks++; if (c_wr_en !== 1'b0) begin errors++; $display("FAIL rclr_no_acc got=%b exp=0", c_wr_en); end
    step();
    $display("test_rclr done");
  endtask

  task automatic test_hold();
    q = 32'h0000_0011; re = 1'b1; rsp_ready = 1'b1;
    step();
    q = 32'h0000_0022; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (c_rsp_valid !== 1'b1 || c_rsp_data !== 32'h11) begin
        errors++; $display("FAIL hold_rsp cyc=%0d got=%b/%h exp=1/11", i, c_rsp_valid, c_rsp_data); end
      checks++; if (c_re_ready !== 1'b0 || c_wr_en !== 1'b0) begin
        errors++; $display("FAIL hold_blocked cyc=%0d got=ready%b/wr%b exp=0/0", i, c_re_ready, c_wr_en); end
      step();
    end
    re = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++; if (c_rsp_data !== 32'h11 || c_re_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got=%h/%b exp=11/1", c_rsp_data, c_re_ready); end
    step();
    checks++; if (c_rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got=%b exp=0", c_rsp_valid); end
    $display("test_hold done");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    rsp_ready = 1'b1; re = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      q = i;
      #1;
      checks++; if (c_re_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, c_re_ready); end
      if (c_wr_en === 1'b1) pulses++;
      if (i > 1) begin
        checks++; if (c_rsp_valid !== 1'b1 || c_rsp_data !== i - 1) begin
          errors++; $display("FAIL b2b_rsp i=%0d got=%b/%h exp=1/%h", i, c_rsp_valid, c_rsp_data, i - 1); end
      end
      step();
    end
    re = 1'b0;
    #1;
    checks++; if (c_rsp_valid !== 1'b1 || c_rsp_data !== 32'h4) begin
      errors++; $display("FAIL b2b_last got=%b/%h exp=1/4", c_rsp_valid, c_rsp_data); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_wr_pulses got=%0d exp=4", pulses); end
    step();
    $display("test_back_to_back done");
  endtask

  task automatic test_arb_reset();
    q = 32'h77; re = 1'b1; arb_wr_en = 1'b1; arb_wr_data = 32'h5; rsp_ready = 1'b1;
    #1;
    checks++; if (s_wr_en !== 1'b1 || s_wr_data !== 32'h5) begin
      errors++; $display("FAIL arb_over_rset got=%b/%h exp=1/5", s_wr_en, s_wr_data); end
    checks++; if (c_wr_data !== 32'h5 || n_wr_en !== 1'b1) begin
      errors++; $display("FAIL arb_over_rclr got=%h/%b exp=5/1", c_wr_data, n_wr_en); end
    step();
    re = 1'b0; arb_wr_en = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++; if (s_rsp_valid !== 1'b1 || s_rsp_data !== 32'h77) begin
      errors++; $display("FAIL arb_pre_write_q got=%b/%h exp=1/77", s_rsp_valid, s_rsp_data); end
    rst = 1'b1; re = 1'b1;
    #1;
    checks++; if (s_re_ready !== 1'b0 || s_wr_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_gate got=%b/%b exp=0/0", s_re_ready, s_wr_en); end
    step();
    rst = 1'b0; idle_inputs();
    #1;
    checks++; if (s_rsp_valid !== 1'b0 || s_rsp_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_drop got=%b/%h exp=0/0", s_rsp_valid, s_rsp_data); end
    step();
    $display("test_arb_reset done");
  endtask

`ifdef RDL_SUBREG_RD_SWACC_EN
  task automatic test_swacc();
    logic [5:0] pat = 6'b000101;
    logic       prev = 1'b0;
    int         pulses = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      re = pat[i]; q = 32'h100 + i;
      #1;
      checks++; if (n_swacc !== prev) begin errors++; $display("FAIL swacc_cyc%0d got=%b exp=%b", i, n_swacc, prev); end
      if (n_swacc === 1'b1) pulses++;
      prev = pat[i];
      step();
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL swacc_pulses got=%0d exp=2", pulses); end
    $display("test_swacc done");
  endtask
`endif

  // Reference: at most one held response, in order; a read is accepted when
  // there is no response held or the held one is consumed in the same cycle.
  task automatic test_random();
    logic [31:0] held[$];
    logic        prev_acc = 1'b0;
    logic        ready, acc, got_en, exp_en;
    logic [31:0] got_data, exp_data;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst         = (cyc == 0) || ($urandom_range(0, 39) == 0);
      re          = $urandom_range(0, 2) != 0;
      rsp_ready   = $urandom_range(0, 2) != 0;
      q           = $urandom;
      de          = $urandom_range(0, 1) == 1;
      d           = $urandom;
      arb_wr_en   = $urandom_range(0, 4) == 0;
      arb_wr_data = $urandom;
      #1;
      ready = !rst && (held.size() == 0 || rsp_ready);
      acc   = re && ready;
      if (cyc > 0) begin
        checks++; if (n_rsp_valid !== (held.size() != 0)) begin
          errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, n_rsp_valid, held.size() != 0); end
        if (held.size() != 0) begin
          checks++; if (n_rsp_data !== held[0]) begin
            errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, n_rsp_data, held[0]); end
        end
`ifdef RDL_SUBREG_RD_SWACC_EN
        checks++; if (n_swacc !== prev_acc) begin
          errors++; $display("FAIL rnd_swacc cyc=%0d got=%b exp=%b", cyc, n_swacc, prev_acc); end
`endif
      end
      checks++; if (n_re_ready !== ready || c_re_ready !== ready || s_re_ready !== ready) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b%b%b exp=%b", cyc, n_re_ready, c_re_ready, s_re_ready, ready); end
      for (int m = 0; m < 3; m++) begin
        case (m)
          0:       begin got_en = n_wr_en; got_data = n_wr_data; end
          1:       begin got_en = c_wr_en; got_data = c_wr_data; end
          default: begin got_en = s_wr_en; got_data = s_wr_data; end
        endcase
        exp_en = 1'b0; exp_data = '0;
        if (rst) exp_en = 1'b0;
        else if (arb_wr_en) begin exp_en = 1'b1; exp_data = arb_wr_data; end
        else if (acc && m == 1) begin exp_en = 1'b1; exp_data = de ? d : 32'h0; end
        else if (acc && m == 2) begin exp_en = 1'b1; exp_data = 32'hFFFF_FFFF; end
        checks++; if (got_en !== exp_en || (exp_en && got_data !== exp_data)) begin
          errors++; $display("FAIL rnd_wr mode=%0d cyc=%0d got=%b/%h exp=%b/%h", m, cyc, got_en, got_data, exp_en, exp_data); end
      end
      if (rst) begin
        held.delete();
        prev_acc = 1'b0;
      end else begin
        if (held.size() != 0 && rsp_ready) void'(held.pop_front());
        if (acc) held.push_back(q);
        prev_acc = acc;
      end
      step();
    end
    rst = 1'b0; idle_inputs();
    step();
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read_none();
    test_rclr();
    test_hold();
    test_back_to_back();
    test_arb_reset();
`ifdef RDL_SUBREG_RD_SWACC_EN
    test_swacc();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
